aes_sub_srow: RTL and testbench

- Encryption-round front end: applies SubBytes, then ShiftRows, to one 16-byte AES state.
- Feeds the MixColumns stage directly. Its State_out has the same byte layout MixColumns consumes: byte index 4*c+r, where c is the column and r is the row.
- Computes the S-box arithmetically from the shared GF(2^8) EXP3/LN3 tables, not from a stored S-box ROM.
- Processes BPC bytes per cycle under a valid/ready handshake; the result is registered.

---
 rtl/aes_sub_srow.sv | 111 +++++++++++
 tb/tb_aes_sub_srow.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sub_srow.sv
// AES encryption-round front end: SubBytes (S-box computed from EXP3/LN3 tables)
// followed by ShiftRows, BPC bytes per cycle, valid/ready handshake, registered result.
module aes_sub_srow #(
    parameter int unsigned BPC = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           valid_in,
    output logic           ready_in,
    input  logic [127:0]   State_in,
    input  logic [2047:0]  EXP3,
    input  logic [2047:0]  LN3,
    output logic           valid_out,
    input  logic           ready_out,
    output logic [127:0]   State_out
);

    localparam int unsigned NB     = 4;
    localparam int unsigned NBYTES = 4 * NB;
    localparam int unsigned NCHUNK = NBYTES / BPC;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [127:0]    sbuf, sbuf_nxt;
    logic [127:0]    state_out_nxt;
    logic [3:0]      lane_idx;

    // Multiplicative inverse via log/antilog, then the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x,
                                        input logic [2047:0] exp3,
                                        input logic [2047:0] ln3);
        logic [8:0] e;
        logic [7:0] inv;
        e = 9'd255 - {1'b0, ln3[{x, 3'b000} +: 8]};
        if (e == 9'd255) e = 9'd0;
        inv = (x == 8'h00) ? 8'h00 : exp3[{e[7:0], 3'b000} +: 8];
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%NB)+r) +: 8];
            end
        end
        return o;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sbuf      <= '0;
            State_out <= '0;
            valid_out <= 1'b0;
            ready_in  <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sbuf      <= sbuf_nxt;
            State_out <= state_out_nxt;
            valid_out <= (state_nxt == DONE);
            ready_in  <= (state_nxt == IDLE);
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        sbuf_nxt      = sbuf;
        state_out_nxt = State_out;
        lane_idx      = '0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    sbuf_nxt  = State_in;
                    cnt_nxt   = '0;
                    state_nxt = SUB;
                end
            end
            SUB: begin
                // Substitute this cycle's chunk in place.
                for (int unsigned j = 0; j < BPC; j++) begin
                    lane_idx = 4'(32'(cnt) * BPC + j);
                    sbuf_nxt[{lane_idx, 3'b000} +: 8] =
                        sbox(sbuf[{lane_idx, 3'b000} +: 8], EXP3, LN3);
                end
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(NCHUNK - 1)) begin
                    state_out_nxt = shift_rows(sbuf_nxt);
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                if (ready_out) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_sub_srow.sv
// Bench for aes_sub_srow: one instance per legal BPC, directed vectors plus random
// states checked against a brute-force GF(2^8) S-box reference.
module tb_aes_sub_srow;

    logic           clock;
    logic           reset;
    logic [127:0]   state_in;
    logic [2047:0]  exp3_v;
    logic [2047:0]  ln3_v;
    logic           valid_in  [5];
    logic           ready_in  [5];
    logic           valid_out [5];
    logic           ready_out [5];
    logic [127:0]   state_out [5];

    int n_assert;
    int n_fail;
    logic [7:0] sbox_ref [256];

    for (genvar g = 0; g < 5; g++) begin : g_dut
        aes_sub_srow #(.BPC(1 << g)) u_dut (
            .clock     (clock),
            .reset     (reset),
            .valid_in  (valid_in[g]),
            .ready_in  (ready_in[g]),
            .State_in  (state_in),
            .EXP3      (exp3_v),
            .LN3       (ln3_v),
            .valid_out (valid_out[g]),
            .ready_out (ready_out[g]),
            .State_out (state_out[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // FIPS-197 bitwise affine form applied to the brute-force inverse.
    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] inv, s, c;
        inv = 8'h00;
        c = 8'h63;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return s;
    endfunction

    // Reference: row r of the output takes the substituted row r rotated left by r.
    function automatic logic [127:0] model(input logic [127:0] s);
        logic [7:0]   m [4][4];
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = sbox_ref[s[8*(4*c+r) +: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = m[r][(c+r)%4];
        return o;
    endfunction

    // Converts a literal written byte-0-first into the port layout (byte i at [8i+:8]).
    function automatic logic [127:0] bytes(input logic [127:0] lit);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = lit[127-8*i -: 8];
        return o;
    endfunction

    function automatic logic [31:0] mixcol0(input logic [127:0] s);
        logic [7:0] a0, a1, a2, a3;
        a0 = s[7:0]; a1 = s[15:8]; a2 = s[23:16]; a3 = s[31:24];
        return {gmul(a0,8'h02) ^ gmul(a1,8'h03) ^ a2 ^ a3,
                a0 ^ gmul(a1,8'h02) ^ gmul(a2,8'h03) ^ a3,
                a0 ^ a1 ^ gmul(a2,8'h02) ^ gmul(a3,8'h03),
                gmul(a0,8'h03) ^ a1 ^ a2 ^ gmul(a3,8'h02)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one state on instance k; returns the result and edges-to-valid (bounded).
    task automatic run(input int k, input logic [127:0] din, output logic [127:0] dout,
                       output int lat);
        @(negedge clock);
        state_in    = din;
        valid_in[k] = 1'b1;
        @(posedge clock);
        #1 valid_in[k] = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clock);
            lat++;
            #1;
            if (valid_out[k]) break;
        end
        dout = state_out[k];
    endtask

    task automatic release_out(input int k);
        @(negedge clock);
        ready_out[k] = 1'b1;
        @(posedge clock);
        #1 ready_out[k] = 1'b0;
    endtask

    initial begin
        logic [127:0] fips_in, fips_out, corner_in, corner_out, got, held, rnd;
        int lat, k;

        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        state_in = '0;
        for (int i = 0; i < 5; i++) begin
            valid_in[i]  = 1'b0;
            ready_out[i] = 1'b0;
        end

        // Antilog/log tables for generator 0x03.
        begin
            logic [7:0] e;
            e = 8'h01;
            ln3_v = '0;
            for (int i = 0; i < 255; i++) begin
                exp3_v[8*i +: 8] = e;
                ln3_v[8*e +: 8]  = 8'(i);
                e = gmul(e, 8'h03);
            end
            exp3_v[8*255 +: 8] = 8'h01;
        end
        for (int i = 0; i < 256; i++) sbox_ref[i] = sbox_model(8'(i));

        fips_in    = bytes(128'h193DE3BE_A0F4E22B_9AC68D2A_E9F84808);
        fips_out   = bytes(128'hD4BF5D30_E0B452AE_B84111F1_1E2798E5);
        corner_in  = bytes(128'h000153FF_000153FF_000153FF_000153FF);
        corner_out = bytes(128'h637CED16_637CED16_637CED16_637CED16);

        repeat (2) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("reset_ready_in[%0d]", i), 128'(ready_in[i]), 128'(1));
            check($sformatf("reset_valid_out[%0d]", i), 128'(valid_out[i]), 128'(0));
            check($sformatf("reset_state_out[%0d]", i), state_out[i], '0);
        end
        reset = 1'b1;

        // FIPS-197 round 1 at BPC=4.
        run(2, fips_in, got, lat);
        check("fips_bpc4", got, fips_out);
        check("fips_bpc4_model", got, model(fips_in));
        check("fips_bpc4_latency", 128'(lat), 128'(4));
        check("fips_mixcol0", 128'(mixcol0(got)), 128'(32'h046681E5));

        // Backpressure: result held, no accept, while ready_out stays low.
        held = got;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_valid_out", 128'(valid_out[2]), 128'(1));
            check("bp_ready_in", 128'(ready_in[2]), 128'(0));
            check("bp_state_out", state_out[2], held);
            valid_in[2] = i[0];
            state_in    = corner_in;
        end
        @(negedge clock);
        valid_in[2]  = 1'b0;
        ready_out[2] = 1'b1;
        @(posedge clock);
        #1 ready_out[2] = 1'b0;
        check("bp_release_ready_in", 128'(ready_in[2]), 128'(1));
        check("bp_release_valid_out", 128'(valid_out[2]), 128'(0));
        repeat (6) @(posedge clock);
        #1 check("bp_no_accept", 128'(valid_out[2]), 128'(0));

        // S-box corner values: columns identical so ShiftRows is a no-op.
        run(2, corner_in, got, lat);
        check("corner", got, corner_out);
        check("corner_latency", 128'(lat), 128'(4));
        release_out(2);

        // Reset asserted two edges into SUB.
        @(negedge clock);
        state_in    = fips_in;
        valid_in[2] = 1'b1;
        @(posedge clock);
        #1 valid_in[2] = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midsub_valid_out", 128'(valid_out[2]), 128'(0));
        check("midsub_state_out", state_out[2], '0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midsub_ready_in", 128'(ready_in[2]), 128'(1));
        run(2, fips_in, got, lat);
        check("midsub_after", got, fips_out);
        check("midsub_after_latency", 128'(lat), 128'(4));
        release_out(2);

        // BPC sweep: same result, latency 16/BPC.
        for (int i = 0; i < 5; i++) begin
            if (i == 2) continue;
            run(i, fips_in, got, lat);
            check($sformatf("sweep_out[bpc=%0d]", 1 << i), got, fips_out);
            check($sformatf("sweep_lat[bpc=%0d]", 1 << i), 128'(lat), 128'(16 >> i));
            release_out(i);
        end

        // Random states on random instances.
        for (int n = 0; n < 24; n++) begin
            k   = int'($urandom_range(0, 4));
            rnd = {$urandom, $urandom, $urandom, $urandom};
            run(k, rnd, got, lat);
            check($sformatf("rand%0d_out[bpc=%0d]", n, 1 << k), got, model(rnd));
            check($sformatf("rand%0d_lat[bpc=%0d]", n, 1 << k), 128'(lat), 128'(16 >> k));
            repeat ($urandom_range(0, 3)) @(posedge clock);
            release_out(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
